dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the NPC core: the memory-side end of the load/store request interface driven by the core's load/store path. It accepts one request at a time over a valid/ready handshake and performs byte-lane alignment and load sign/zero extension. It holds the request for a fixed, parameterised latency, then returns a response over a second valid/ready handshake. It stands in for a multi-cycle data SRAM, so the core's memory stage can be exercised against non-zero latency and back-pressure.

## Interface
- `ADDR_W`, 32: request address width.
- `DEPTH_WORDS`, 1024: memory depth in 32-bit words; power of two.
- `LATENCY`, 2: cycles spent in WAIT before access; ≥1.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; equals (state == IDLE).
- `req_store`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_sext`  in  1  load only: 1 = sign-extend, 0 = zero-extend.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  32  load result, extended; 0 for stores and errors.
- `resp_err`  out  1  access not performed.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE: `req_ready` = 1. On `req_valid & req_ready`, latch store, addr, wdata, size and sext. Load the counter with LATENCY-1 and go to WAIT.
- WAIT: each cycle, if counter ≠ 0, decrement it. If counter == 0, perform the access, register `resp_rdata`/`resp_err`, and go to RESP.
- RESP: `resp_valid` = 1. Outputs hold stable until `resp_valid & resp_ready`, then go to IDLE.
- Address decode: offset = addr − BASE_ADDR. The request is in range iff addr ≥ BASE_ADDR and offset < 4·DEPTH_WORDS. Word index = offset[log2(DEPTH_WORDS)+1:2].
- Error conditions: out of range, or `req_size` = 11. On error: no write, `resp_err` = 1, `resp_rdata` = 0.
- Store lanes:
  - byte writes lane addr[1:0] with wdata[7:0].
  - half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - word writes all lanes.
  - Other bytes are unchanged.
- Load extraction uses the same lanes. The extracted field is extended to 32 bits per `req_sext`; word ignores `req_sext`.
- Stores return `resp_rdata` = 0 and `resp_err` = 0 on success.
- Memory array is not reset; contents are undefined until written.

## Timing
- Reset values: state IDLE, `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, counter 0. `req_ready` reads 1 during reset, but no request is latched while `rst_n` = 0.
- Acceptance edge E0 → `resp_valid` high after edge E0+LATENCY. The memory write commits at that same edge.
- A response handshake at edge En → `req_ready` high after En. The next acceptance is at En+1 at the earliest, giving a throughput of one access per LATENCY+2 cycles.
- `resp_ready` low holds RESP indefinitely with `resp_rdata`/`resp_err` unchanged.
- `req_valid` is ignored outside IDLE; the requester must hold its request until `req_ready`.
- Reset asserted in WAIT: the pending store is not written. Reset asserted in RESP: the response is dropped.
- A load issued after a store's response handshake observes the stored data.

## Configuration
- `DMEM_MISALIGN_TRAP_EN`:
  - Defined: half with addr[0] = 1, or word with addr[1:0] ≠ 00, returns `resp_err` = 1 and `resp_rdata` = 0, with no write. Latency is unchanged.
  - Undefined: the low address bits are forced aligned. For half, addr[0] is treated as 0; for word, addr[1:0] is treated as 00. The access proceeds with `resp_err` = 0.

## Test plan
- Word store 0xDEADBEEF at 0x8000_0010, then word load from the same address → `resp_rdata` 0xDEADBEEF, `resp_err` 0. `resp_valid` rises exactly LATENCY cycles after each acceptance.
- Byte store 0x80 at 0x8000_0021, then byte load from the same address with sext=1 → 0xFFFF_FF80. The same load with sext=0 → 0x0000_0080. Lanes 0, 2 and 3 of the word are unchanged.
- Half store 0xA5A5 at 0x8000_0032, then half load zero-extended → 0x0000_A5A5. A word load of 0x8000_0030 shows the half in bits [31:16].
- Load from 0x7FFF_FFFC, then load from BASE_ADDR + 4·DEPTH_WORDS → `resp_err` 1, `resp_rdata` 0. A store to the same out-of-range address does not alter any memory word.
- Half load at 0x8000_0041:
  - With the macro defined → `resp_err` 1.
  - Without the macro → returns the half at 0x8000_0040, `resp_err` 0.
- `resp_ready` held low for 5 cycles in RESP → `resp_valid`/`resp_rdata` stable and `req_ready` 0 throughout.
- `rst_n` pulsed low during WAIT of a store → the word is unchanged on a later load, and `resp_valid` stays 0 until the next accepted request.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory model behind a valid/ready load/store port.
// Optional build macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module dmem_responder #(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter int                LATENCY     = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h8000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(4 * DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              accept;
    logic              access;

    logic              store_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              sext_q;

    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [ADDR_W-1:0] offset;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lo;
    logic              misalign;
    logic              err;
    logic [3:0]        be;
    logic [31:0]       wlane;
    logic [31:0]       rd_word;
    logic [31:0]       merged;
    logic [31:0]       ld_val;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        access     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_INIT;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else begin
                    access     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and countdown registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Capture the request on acceptance; it stays put until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
        end else if (accept) begin
            store_q <= req_store;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size;
            sext_q  <= req_sext;
        end
    end

    // Address window check and word index.
    always_comb begin
        offset   = addr_q - BASE_ADDR;
        in_range = (addr_q >= BASE_ADDR) && ({1'b0, offset} < SPAN);
        idx      = offset[IDX_W+1:2];
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Misaligned half/word accesses are refused; lane offset is used as given.
    always_comb begin
        lo       = addr_q[1:0];
        misalign = ((size_q == 2'b01) && addr_q[0]) ||
                   ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
    end
`else
    // Misaligned half/word accesses are silently aligned down.
    always_comb begin
        misalign = 1'b0;
        unique case (size_q)
            2'b01:   lo = {addr_q[1], 1'b0};
            2'b10:   lo = 2'b00;
            default: lo = addr_q[1:0];
        endcase
    end
`endif

    // Lane enables, replicated store data and extended load value.
    always_comb begin
        err      = !in_range || (size_q == 2'b11) || misalign;
        rd_word  = mem[idx];
        byte_sel = rd_word[{lo, 3'b000} +: 8];
        half_sel = lo[1] ? rd_word[31:16] : rd_word[15:0];
        be       = 4'b0000;
        wlane    = '0;
        ld_val   = '0;
        unique case (size_q)
            2'b00: begin
                be     = 4'b0001 << lo;
                wlane  = {4{wdata_q[7:0]}};
                ld_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                be     = lo[1] ? 4'b1100 : 4'b0011;
                wlane  = {2{wdata_q[15:0]}};
                ld_val = {{16{sext_q & half_sel[15]}}, half_sel};
            end
            2'b10: begin
                be     = 4'b1111;
                wlane  = wdata_q;
                ld_val = rd_word;
            end
            default: begin
                be     = 4'b0000;
            end
        endcase
    end

    // Merge enabled store lanes over the current word.
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wlane[8*i +: 8];
            end
        end
    end

    // Storage array; only written by a successful store at the access edge.
    always_ff @(posedge clk) begin
        if (access && store_q && !err) begin
            mem[idx] <= merged;
        end
    end

    // Response registers, loaded at the access edge and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (access) begin
            err_q   <= err;
            rdata_q <= (err || store_q) ? 32'h0 : ld_val;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed load/store sequences checked against a
// byte-addressed reference memory and hand-computed response values.
module tb_dmem_responder;

    localparam int          LAT   = 2;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sext;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    dmem_responder #(
        .ADDR_W      (32),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .req_sext   (req_sext),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference memory: one entry per written byte address.
    logic [7:0]  bmem [logic [31:0]];
    logic [31:0] pw_a [4];
    logic [7:0]  pw_d [4];
    int          pw_n = 0;
    bit          pend = 0;
    int          commit_edge = 0;

    typedef struct {
        logic [31:0] rd;
        logic        e;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   edge_n   = 0;
    int   last_acc = -1;

    function automatic void predict(input logic st, input logic [31:0] a,
                                    input logic [31:0] wd, input logic [1:0] sz,
                                    input logic sx, output logic [31:0] rd,
                                    output logic e);
        longint      off;
        int          n;
        logic [31:0] ea;
        logic [31:0] v;
        off = longint'(a) - longint'(BASE);
        e   = (off < 0) || (off >= 4 * DEPTH) || (sz == 2'b11);
        ea  = a;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) e = 1'b1;
`else
        if (sz == 2'b01) ea[0] = 1'b0;
        if (sz == 2'b10) ea[1:0] = 2'b00;
`endif
        rd   = '0;
        pw_n = 0;
        if (!e) begin
            n = 1 << sz;
            if (st) begin
                for (int i = 0; i < n; i++) begin
                    pw_a[i] = 32'(ea + i);
                    pw_d[i] = wd[8*i +: 8];
                end
                pw_n = n;
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) begin
                    if (bmem.exists(32'(ea + i))) v[8*i +: 8] = bmem[32'(ea + i)];
                end
                if (sx && n < 4 && v[8*n-1]) begin
                    for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
                end
                rd = v;
            end
        end
    endfunction

    // Track accepted requests, store commit time and response handshakes.
    always @(posedge clk or negedge rst_n) begin
        logic [31:0] m_rd;
        logic        m_e;
        exp_t        x;
        if (!rst_n) begin
            q.delete();
            pend = 0;
        end else begin
            edge_n++;
            if (pend && edge_n == commit_edge) begin
                for (int k = 0; k < pw_n; k++) bmem[pw_a[k]] = pw_d[k];
                pend = 0;
            end
            if (resp_valid && resp_ready && q.size() > 0) void'(q.pop_front());
            if (req_valid && req_ready) begin
                predict(req_store, req_addr, req_wdata, req_size, req_sext, m_rd, m_e);
                x.rd  = m_rd;
                x.e   = m_e;
                x.acc = edge_n;
                q.push_back(x);
                if (pw_n > 0) begin
                    pend        = 1;
                    commit_edge = edge_n + LAT;
                end
            end
        end
    end

    // Every cycle out of reset: response contents, latency and ready.
    always @(negedge clk) begin
        if (rst_n) begin
            if (resp_valid) begin
                chk("resp_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    chk("resp_rdata", resp_rdata, q[0].rd);
                    chk("resp_err", 32'(resp_err), 32'(q[0].e));
                    chk("ready_in_resp", 32'(req_ready), 32'd0);
                    if (q[0].acc != last_acc) begin
                        chk("latency", 32'(edge_n - q[0].acc), 32'(LAT));
                        last_acc = q[0].acc;
                    end
                end
            end else begin
                chk("req_ready", 32'(req_ready), 32'(q.size() == 0));
            end
        end
    end

    task automatic xact(input logic st, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sx, input int hold,
                        input logic [31:0] er, input logic ee);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_store = st;
        req_addr  = a;
        req_wdata = wd;
        req_size  = sz;
        req_sext  = sx;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: addr %h got no req_ready want 1", a);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: addr %h got no resp_valid want 1", a);
            return;
        end
        chk("lit_rdata", resp_rdata, er);
        chk("lit_err", 32'(resp_err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, er);
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_addr   = BASE;
        req_wdata  = 32'h1234_5678;
        req_size   = 2'b10;
        req_sext   = 1'b0;
        resp_ready = 1'b0;

        // Reset values, with a request pending that must not be taken.
        repeat (2) begin
            @(negedge clk);
            chk("rst_valid", 32'(resp_valid), 32'd0);
            chk("rst_rdata", resp_rdata, 32'd0);
            chk("rst_err", 32'(resp_err), 32'd0);
            chk("rst_ready", 32'(req_ready), 32'd1);
        end
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (LAT + 2) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(resp_valid), 32'd0);
        end

        // Word store and load back.
        xact(1, 32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 0, 0, 32'h0, 0);
        xact(0, 32'h8000_0010, 32'h0, 2'b10, 0, 0, 32'hDEAD_BEEF, 0);

        // Byte lane write and signed/unsigned byte loads.
        xact(1, 32'h8000_0020, 32'h1122_3344, 2'b10, 0, 0, 32'h0, 0);
        xact(1, 32'h8000_0021, 32'h0000_0080, 2'b00, 0, 0, 32'h0, 0);
        xact(0, 32'h8000_0021, 32'h0, 2'b00, 1, 0, 32'hFFFF_FF80, 0);
        xact(0, 32'h8000_0021, 32'h0, 2'b00, 0, 0, 32'h0000_0080, 0);
        xact(0, 32'h8000_0020, 32'h0, 2'b10, 0, 0, 32'h1122_8044, 0);

        // Upper half write and half loads.
        xact(1, 32'h8000_0030, 32'h0, 2'b10, 0, 0, 32'h0, 0);
        xact(1, 32'h8000_0032, 32'h0000_A5A5, 2'b01, 0, 0, 32'h0, 0);
        xact(0, 32'h8000_0032, 32'h0, 2'b01, 0, 0, 32'h0000_A5A5, 0);
        xact(0, 32'h8000_0032, 32'h0, 2'b01, 1, 0, 32'hFFFF_A5A5, 0);
        xact(0, 32'h8000_0030, 32'h0, 2'b10, 0, 0, 32'hA5A5_0000, 0);

        // Out of range and reserved size.
        xact(1, 32'h8000_0000, 32'h0102_0304, 2'b10, 0, 0, 32'h0, 0);
        xact(0, 32'h7FFF_FFFC, 32'h0, 2'b10, 0, 0, 32'h0, 1);
        xact(0, 32'h8000_1000, 32'h0, 2'b10, 0, 0, 32'h0, 1);
        xact(1, 32'h8000_1000, 32'hFFFF_FFFF, 2'b10, 0, 0, 32'h0, 1);
        xact(1, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 0, 0, 32'h0, 1);
        xact(0, 32'h8000_0000, 32'h0, 2'b10, 0, 0, 32'h0102_0304, 0);
        xact(0, 32'h8000_0010, 32'h0, 2'b10, 0, 0, 32'hDEAD_BEEF, 0);

        // Misaligned half and word.
        xact(1, 32'h8000_0040, 32'hCAFE_1234, 2'b10, 0, 0, 32'h0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
        xact(0, 32'h8000_0041, 32'h0, 2'b01, 0, 0, 32'h0, 1);
        xact(0, 32'h8000_0043, 32'h0, 2'b10, 0, 0, 32'h0, 1);
`else
        xact(0, 32'h8000_0041, 32'h0, 2'b01, 0, 0, 32'h0000_1234, 0);
        xact(0, 32'h8000_0043, 32'h0, 2'b10, 0, 0, 32'hCAFE_1234, 0);
`endif

        // Back-pressure: response held for five cycles.
        xact(0, 32'h8000_0010, 32'h0, 2'b10, 0, 5, 32'hDEAD_BEEF, 0);

        // Reset during WAIT of a store: the store must be lost.
        @(negedge clk);
        req_valid = 1'b1;
        req_store = 1'b1;
        req_addr  = 32'h8000_0010;
        req_wdata = 32'hFFFF_0000;
        req_size  = 2'b10;
        chk("pre_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("after_rst_valid", 32'(resp_valid), 32'd0);
        end
        xact(0, 32'h8000_0010, 32'h0, 2'b10, 0, 0, 32'hDEAD_BEEF, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
